addsub_arbiter: RTL and testbench
=================================

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; ports are listed clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 req0_ready / req1_ready  output  1  requester n operation accepted this cycle.
REQ-006 req0_ctrl / req1_ctrl  input  1  operation select: 0 = add, 1 = subtract.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  3  two's-complement operands.
REQ-008 res_valid  output  1  result register holds an undelivered result.
REQ-009 res_ready  input  1  consumer accepts the result this cycle.
REQ-010 res_s  output  5  two's-complement result, sign-extended.
REQ-011 res_id  output  1  index of the requester that issued the result.
REQ-012 op_count0 / op_count1  output  8  accepted-operation count per requester.

Function
REQ-013 The shared arithmetic unit SHALL compute res_s = a + b when ctrl = 0 and a - b when ctrl = 1, with both operands sign-extended to 5 bits; results range -8..+7 and SHALL never overflow.
REQ-014 Result register states: EMPTY (res_valid = 0) and FULL (res_valid = 1).
REQ-015 can_accept = EMPTY, or FULL with res_ready = 1 (drain and refill in the same cycle).
REQ-016 At most one request SHALL be granted per cycle; reqN_ready = 1 only for the granted requester, only when can_accept = 1 and reqN_valid = 1.
REQ-017 Single valid requester: that requester SHALL be granted.
REQ-018 Both requesters valid: round-robin. The requester not granted last SHALL win; last_grant updates only on an actual grant.
REQ-019 reqN_ready SHALL be combinational from valid, last_grant, the result-register state and res_ready.
REQ-020 Latency: a request accepted at edge N SHALL appear on res_s/res_id with res_valid = 1 after edge N; one cycle.
REQ-021 FULL with res_ready = 0: res_s, res_id and res_valid SHALL hold, and both reqN_ready SHALL be 0.
REQ-022 FULL with res_ready = 1 and no grant: the register SHALL go EMPTY.
REQ-023 FULL with res_ready = 1 and a grant: the register SHALL stay FULL with the new result; throughput is one op per cycle.
REQ-024 Requester inputs are sampled only on the accept edge; a change while not ready has no effect.
REQ-025 op_countN SHALL increment on each accept from requester N and wrap 255 -> 0.

Reset
REQ-026 When rst = 1 at a clock edge: res_valid = 0, res_s = 0, res_id = 0, op_count0 = op_count1 = 0, and last_grant = 1, so requester 0 wins the first contention.
REQ-027 During rst = 1, both reqN_ready SHALL be 0 and no operation is accepted.
REQ-028 Reset mid-operation SHALL discard any held result; no result is delivered after reset deasserts.

Structure
REQ-029 A shared package SHALL hold the operand width (3), result width (5), counter width (8), the add/subtract encoding constants, and the EMPTY/FULL state type.
REQ-030 The arithmetic SHALL be one combinational sub-module, addsub_unit (ctrl, a, b -> s[4:0]), instantiated once and fed through a grant-driven 2:1 operand mux.

Verification
REQ-031 Reset, then req0: ctrl = 0, a = 3, b = 2; res_ready = 1 -> next cycle res_valid = 1, res_s = 5, res_id = 0, op_count0 = 1.
REQ-032 req1: ctrl = 1, a = -4, b = 3 -> res_s = -7 (5'b11001), res_id = 1; and a = 3, b = -4 subtract -> res_s = 7.
REQ-033 Both valid for 4 cycles with res_ready = 1 -> grants in order 0, 1, 0, 1, one result per cycle.
REQ-034 res_ready = 0 for 3 cycles with both valid -> res_s held, no reqN_ready; on release, a grant in the same cycle as the drain.
REQ-035 256 accepts from req0 -> op_count0 wraps to 0; op_count1 unchanged.
REQ-036 rst asserted while FULL with res_ready = 0 -> next cycle res_valid = 0, counters 0, and the first contention after reset grants req0.

Source files
------------

// File: rtl/addsub_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : addsub_arbiter_pkg
// Purpose  : Shared widths, operation encoding and result-register state type.
// Revision : 1.0 - initial release
// ============================================================================
package addsub_arbiter_pkg;

   localparam int c_OP_W  = 3;
   localparam int c_RES_W = 5;
   localparam int c_CNT_W = 8;

   localparam logic c_CTRL_ADD = 1'b0;
   localparam logic c_CTRL_SUB = 1'b1;

   typedef enum logic [0:0] {
      RES_EMPTY = 1'b0,
      RES_FULL  = 1'b1
   } res_state_t;

   function automatic logic [c_RES_W-1:0] sext_op(input logic [c_OP_W-1:0] x);
      return {{(c_RES_W-c_OP_W){x[c_OP_W-1]}}, x};
   endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_arbiter_addsub.sv
`default_nettype none
// ============================================================================
// Module   : addsub_unit
// Purpose  : Combinational 3-bit signed add/subtract with 5-bit signed result.
// Revision : 1.0 - initial release
// ============================================================================
module addsub_unit
   import addsub_arbiter_pkg::*;
(
   input  logic               i_ctrl,
   input  logic [c_OP_W-1:0]  i_a,
   input  logic [c_OP_W-1:0]  i_b,
   output logic [c_RES_W-1:0] o_s
);

   logic [c_RES_W-1:0] w_a_ext;
   logic [c_RES_W-1:0] w_b_ext;

   // Two extra sign bits make -8..+7 reachable without overflow.
   assign w_a_ext = sext_op(i_a);
   assign w_b_ext = sext_op(i_b);
   assign o_s     = (i_ctrl == c_CTRL_SUB) ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);

endmodule
`default_nettype wire

// File: rtl/addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : addsub_arbiter
// Purpose  : Two requesters share one add/sub unit via round-robin grant into
//            a single-entry result register with valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module addsub_arbiter
   import addsub_arbiter_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_req0_valid,
   output logic               o_req0_ready,
   input  logic               i_req0_ctrl,
   input  logic [c_OP_W-1:0]  i_req0_a,
   input  logic [c_OP_W-1:0]  i_req0_b,
   input  logic               i_req1_valid,
   output logic               o_req1_ready,
   input  logic               i_req1_ctrl,
   input  logic [c_OP_W-1:0]  i_req1_a,
   input  logic [c_OP_W-1:0]  i_req1_b,
   output logic               o_res_valid,
   input  logic               i_res_ready,
   output logic [c_RES_W-1:0] o_res_s,
   output logic               o_res_id,
   output logic [c_CNT_W-1:0] o_op_count0,
   output logic [c_CNT_W-1:0] o_op_count1
);

   res_state_t         r_state;
   logic               r_last_grant;
   logic [c_RES_W-1:0] r_res_s;
   logic               r_res_id;
   logic [c_CNT_W-1:0] r_cnt0;
   logic [c_CNT_W-1:0] r_cnt1;

   logic               w_can_accept;
   logic               w_grant0;
   logic               w_grant1;
   logic               w_any_grant;
   logic               w_ctrl;
   logic [c_OP_W-1:0]  w_a;
   logic [c_OP_W-1:0]  w_b;
   logic [c_RES_W-1:0] w_s;

   // Refill is allowed in the same cycle the consumer drains a held result.
   assign w_can_accept = !rst && ((r_state == RES_EMPTY) || i_res_ready);

   assign w_grant0 = w_can_accept && i_req0_valid && (!i_req1_valid || r_last_grant);
   assign w_grant1 = w_can_accept && i_req1_valid && (!i_req0_valid || !r_last_grant);
   assign w_any_grant = w_grant0 || w_grant1;

   assign o_req0_ready = w_grant0;
   assign o_req1_ready = w_grant1;

   always_comb begin
      w_ctrl = i_req0_ctrl;
      w_a    = i_req0_a;
      w_b    = i_req0_b;
      if (w_grant1) begin
         w_ctrl = i_req1_ctrl;
         w_a    = i_req1_a;
         w_b    = i_req1_b;
      end
   end

   addsub_unit u_addsub (
      .i_ctrl (w_ctrl),
      .i_a    (w_a),
      .i_b    (w_b),
      .o_s    (w_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= RES_EMPTY;
         r_res_s      <= '0;
         r_res_id     <= 1'b0;
         r_last_grant <= 1'b1;
         r_cnt0       <= '0;
         r_cnt1       <= '0;
      end else begin
         case (r_state)
            RES_EMPTY: begin
               if (w_any_grant) begin
                  r_state <= RES_FULL;
               end
            end
            RES_FULL: begin
               if (i_res_ready && !w_any_grant) begin
                  r_state <= RES_EMPTY;
               end
            end
            default: r_state <= RES_EMPTY;
         endcase

         if (w_any_grant) begin
            r_res_s      <= w_s;
            r_res_id     <= w_grant1;
            r_last_grant <= w_grant1;
         end
         if (w_grant0) begin
            r_cnt0 <= r_cnt0 + 1'b1;
         end
         if (w_grant1) begin
            r_cnt1 <= r_cnt1 + 1'b1;
         end
      end
   end

   assign o_res_valid = (r_state == RES_FULL);
   assign o_res_s     = r_res_s;
   assign o_res_id    = r_res_id;
   assign o_op_count0 = r_cnt0;
   assign o_op_count1 = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_arbiter
// Purpose  : Directed and randomized self-checking bench for addsub_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       v0 = 0, c0 = 0, v1 = 0, c1 = 0, rr = 0;
   logic [2:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
   logic       rdy0, rdy1, res_valid, res_id;
   logic [4:0] res_s;
   logic [7:0] cnt0, cnt1;

   int checks   = 0;
   int failures = 0;

   // Reference model state: what the result register and counters should hold.
   logic       m_valid = 0;
   logic [4:0] m_s = 0;
   int         m_id = 0;
   int         m_last = 1;
   int         m_cnt[2] = '{0, 0};
   int         m_win = -1;

   always #5 clk = ~clk;

   addsub_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .i_req0_valid (v0),
      .o_req0_ready (rdy0),
      .i_req0_ctrl  (c0),
      .i_req0_a     (a0),
      .i_req0_b     (b0),
      .i_req1_valid (v1),
      .o_req1_ready (rdy1),
      .i_req1_ctrl  (c1),
      .i_req1_a     (a1),
      .i_req1_b     (b1),
      .o_res_valid  (res_valid),
      .i_res_ready  (rr),
      .o_res_s      (res_s),
      .o_res_id     (res_id),
      .o_op_count0  (cnt0),
      .o_op_count1  (cnt1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int op_result(input logic ctrl, input logic [2:0] a, input logic [2:0] b);
      int ai, bi;
      ai = int'($signed(a));
      bi = int'($signed(b));
      return ctrl ? (ai - bi) : (ai + bi);
   endfunction

   // One clock: check grants before the edge, advance the model, check outputs after.
   task automatic step();
      logic can;
      int   r;
      #1;
      can   = !rst && (!m_valid || rr);
      m_win = -1;
      if (can) begin
         if (v0 && v1)  m_win = 1 - m_last;
         else if (v0)   m_win = 0;
         else if (v1)   m_win = 1;
      end
      chk("req0_ready", 32'(rdy0), 32'(m_win == 0));
      chk("req1_ready", 32'(rdy1), 32'(m_win == 1));
      @(posedge clk);
      if (rst) begin
         m_valid = 0; m_s = 0; m_id = 0; m_last = 1; m_cnt = '{0, 0};
      end else if (m_win >= 0) begin
         r       = (m_win == 0) ? op_result(c0, a0, b0) : op_result(c1, a1, b1);
         m_s     = r[4:0];
         m_valid = 1;
         m_id    = m_win;
         m_last  = m_win;
         m_cnt[m_win] = (m_cnt[m_win] + 1) % 256;
      end else if (m_valid && rr) begin
         m_valid = 0;
      end
      #1;
      chk("res_valid", 32'(res_valid), 32'(m_valid));
      if (m_valid) begin
         chk("res_s", 32'(res_s), 32'(m_s));
         chk("res_id", 32'(res_id), 32'(m_id));
      end
      chk("op_count0", 32'(cnt0), 32'(m_cnt[0]));
      chk("op_count1", 32'(cnt1), 32'(m_cnt[1]));
   endtask

   initial begin
      int         order[4];
      logic [7:0] save0, save1;

      // Reset with both requesters pushing: nothing may be granted.
      rst = 1; v0 = 1; v1 = 1; rr = 1;
      step();
      step();
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_s", 32'(res_s), 32'd0);
      chk("rst_res_id", 32'(res_id), 32'd0);
      rst = 0; v0 = 0; v1 = 0;

      // 3 + 2
      v0 = 1; c0 = 0; a0 = 3'd3; b0 = 3'd2;
      step();
      chk("add_3_2", 32'(res_s), 32'd5);
      chk("add_id", 32'(res_id), 32'd0);
      chk("add_cnt0", 32'(cnt0), 32'd1);
      v0 = 0;

      // -4 - 3 and 3 - (-4)
      v1 = 1; c1 = 1; a1 = 3'b100; b1 = 3'd3;
      step();
      chk("sub_m4_3", 32'(res_s), 32'b11001);
      chk("sub_id", 32'(res_id), 32'd1);
      a1 = 3'd3; b1 = 3'b100;
      step();
      chk("sub_3_m4", 32'(res_s), 32'd7);
      v1 = 0;

      // Contention: alternate grants, one result per cycle.
      v0 = 1; v1 = 1; c0 = 0; c1 = 1; a0 = 3'd1; b0 = 3'd1; a1 = 3'd2; b1 = 3'd1;
      for (int i = 0; i < 4; i++) begin
         step();
         order[i] = int'(res_id);
         chk("rr_valid", 32'(res_valid), 32'd1);
      end
      chk("rr_order0", 32'(order[0]), 32'd0);
      chk("rr_order1", 32'(order[1]), 32'd1);
      chk("rr_order2", 32'(order[2]), 32'd0);
      chk("rr_order3", 32'(order[3]), 32'd1);

      // Backpressure: result held, no grants; release drains and refills.
      rr = 0; a0 = 3'd2;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_s", 32'(res_s), 32'd1);
      end
      rr = 1;
      step();
      chk("refill_valid", 32'(res_valid), 32'd1);
      chk("refill_s", 32'(res_s), 32'd3);
      v0 = 0; v1 = 0;
      step();
      chk("drain_empty", 32'(res_valid), 32'd0);

      // 256 accepts from req0 wrap its counter back.
      save0 = cnt0; save1 = cnt1;
      v0 = 1;
      for (int i = 0; i < 256; i++) begin
         a0 = 3'($urandom_range(0, 7)); b0 = 3'($urandom_range(0, 7)); c0 = 1'($urandom_range(0, 1));
         step();
      end
      chk("wrap_cnt0", 32'(cnt0), 32'(save0));
      chk("wrap_cnt1", 32'(cnt1), 32'(save1));

      // Reset while full and stalled.
      rr = 0; v1 = 1;
      step();
      rst = 1;
      step();
      chk("rst_full_valid", 32'(res_valid), 32'd0);
      chk("rst_full_cnt0", 32'(cnt0), 32'd0);
      chk("rst_full_cnt1", 32'(cnt1), 32'd0);
      rst = 0; rr = 1;
      step();
      chk("post_rst_grant", 32'(res_id), 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
         c0 = 1'($urandom_range(0, 1)); c1 = 1'($urandom_range(0, 1));
         a0 = 3'($urandom_range(0, 7)); b0 = 3'($urandom_range(0, 7));
         a1 = 3'($urandom_range(0, 7)); b1 = 3'($urandom_range(0, 7));
         rr = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 49) == 0);
         step();
      end
      rst = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
